// File: rtl/execute_pkg.sv
// Shared operation codes, divider state/op types and control-field bundle for the execute stage.
package execute_pkg;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_PASSB  = 5'd10;
   localparam logic [4:0] ALU_MUL    = 5'd11;
   localparam logic [4:0] ALU_MULH   = 5'd12;
   localparam logic [4:0] ALU_MULHSU = 5'd13;
   localparam logic [4:0] ALU_MULHU  = 5'd14;
   localparam logic [4:0] ALU_DIV    = 5'd15;
   localparam logic [4:0] ALU_DIVU   = 5'd16;
   localparam logic [4:0] ALU_REM    = 5'd17;
   localparam logic [4:0] ALU_REMU   = 5'd18;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
   typedef enum logic [1:0] {DOP_DIV, DOP_DIVU, DOP_REM, DOP_REMU} div_op_e;

   typedef struct packed {
      logic       rd_we;
      logic [4:0] rd_addr;
      logic [1:0] res_src;
      logic       mem_we;
   } ctrl_t;

   function automatic logic is_div_op(input logic [4:0] c);
      return (c == ALU_DIV) || (c == ALU_DIVU) || (c == ALU_REM) || (c == ALU_REMU);
   endfunction

   function automatic div_op_e to_div_op(input logic [4:0] c);
      case (c)
         ALU_DIVU: return DOP_DIVU;
         ALU_REM:  return DOP_REM;
         ALU_REMU: return DOP_REMU;
         default:  return DOP_DIV;
      endcase
   endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute inputs and execute-to-memory outputs bundled as one port group.
interface execute_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic [XLEN-1:0] pc_in;
   logic [XLEN-1:0] next_pc_in;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic            alu_src_a;
   logic            alu_src_b;
   logic [4:0]      alu_ctrl;
   logic            rd_write_enable_in;
   logic [4:0]      rd_write_addr_in;
   logic [1:0]      res_src_in;
   logic            mem_write_enable_in;
   logic            stall_out;
   logic [XLEN-1:0] exec_data_out;
   logic [XLEN-1:0] mem_write_data_out;
   logic            mem_write_enable_out;
   logic [XLEN-1:0] next_pc_out;
   logic            rd_write_enable_out;
   logic [4:0]      rd_write_addr_out;
   logic [1:0]      res_src_out;

   modport master (
      output in_valid, pc_in, next_pc_in, rs1_data, rs2_data, imm, alu_src_a, alu_src_b,
             alu_ctrl, rd_write_enable_in, rd_write_addr_in, res_src_in, mem_write_enable_in,
      input  stall_out, exec_data_out, mem_write_data_out, mem_write_enable_out, next_pc_out,
             rd_write_enable_out, rd_write_addr_out, res_src_out
   );

   modport slave (
      input  in_valid, pc_in, next_pc_in, rs1_data, rs2_data, imm, alu_src_a, alu_src_b,
             alu_ctrl, rd_write_enable_in, rd_write_addr_in, res_src_in, mem_write_enable_in,
      output stall_out, exec_data_out, mem_write_data_out, mem_write_enable_out, next_pc_out,
             rd_write_enable_out, rd_write_addr_out, res_src_out
   );
endinterface

// File: rtl/execute_div_unit.sv
// Iterative restoring divider: magnitudes in, one quotient bit per cycle, sign fixed on the last step.
module div_unit
   import execute_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  div_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   div_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] quo_q, rem_q, dvs_q, res_q;
   logic            neg_q_q, neg_r_q, is_rem_q;

   logic            signed_op, rem_op, a_neg, b_neg, div0, ovf, special, ge, last;
   logic [XLEN-1:0] a_abs, b_abs, spec_res, quo_nx, rem_nx, fix_res;
   logic [XLEN:0]   rem_sh, diff;

   always_comb begin
      signed_op = (op == DOP_DIV) || (op == DOP_REM);
      rem_op    = (op == DOP_REM) || (op == DOP_REMU);
      a_neg     = signed_op & a[XLEN-1];
      b_neg     = signed_op & b[XLEN-1];
      a_abs     = a_neg ? -a : a;
      b_abs     = b_neg ? -b : b;
      div0      = (b == '0);
      ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      special   = div0 | ovf;
      // Overflow quotient is the dividend itself (most negative value).
      if (div0) spec_res = rem_op ? a : '1;
      else      spec_res = rem_op ? '0 : a;
   end

   always_comb begin
      rem_sh  = {rem_q, quo_q[XLEN-1]};
      diff    = rem_sh - {1'b0, dvs_q};
      ge      = ~diff[XLEN];
      rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_nx  = {quo_q[XLEN-2:0], ge};
      fix_res = is_rem_q ? (neg_r_q ? -rem_nx : rem_nx) : (neg_q_q ? -quo_nx : quo_nx);
      last    = (cnt_q == CW'(XLEN-1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DIV_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         DIV_IDLE: if (start) state_d = special ? DIV_DONE : DIV_BUSY;
         DIV_BUSY: begin
            busy = 1'b1;
            if (last) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            done    = 1'b1;
            state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         res_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         is_rem_q <= 1'b0;
      end else if (state_q == DIV_IDLE && start) begin
         if (special) begin
            res_q <= spec_res;
         end else begin
            quo_q    <= a_abs;
            rem_q    <= '0;
            dvs_q    <= b_abs;
            cnt_q    <= '0;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            is_rem_q <= rem_op;
         end
      end else if (state_q == DIV_BUSY) begin
         quo_q <= quo_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + 1'b1;
         if (last) res_q <= fix_res;
      end
   end

   assign result = res_q;

endmodule

// File: rtl/execute.sv
// Execute stage: combinational ALU/multiplier, iterative divider, registered outputs to memory stage.
module execute
   import execute_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input logic       clk,
   input logic       rst_n,
   execute_if.slave  bus
);

   localparam int SW = $clog2(XLEN);

   logic [XLEN-1:0] op_a, op_b, alu_res, mul_res, div_result;
   logic [XLEN-1:0] hold_pc, hold_store;
   logic [SW-1:0]   shamt;
   logic            div_busy, div_done, div_idle, div_start, stall;
   ctrl_t           hold_ctrl;

   assign op_a  = bus.alu_src_a ? bus.pc_in : bus.rs1_data;
   assign op_b  = bus.alu_src_b ? bus.imm   : bus.rs2_data;
   assign shamt = op_b[SW-1:0];

   generate
      if (MUL_EN) begin : g_mul
         logic signed [XLEN:0]   ma, mb;
         logic        [2*XLEN-1:0] prod;
         // 33-bit operands cover every signedness mix; the low 64 product bits are exact.
         always_comb begin
            ma      = $signed({((bus.alu_ctrl == ALU_MULH) || (bus.alu_ctrl == ALU_MULHSU)) & op_a[XLEN-1], op_a});
            mb      = $signed({(bus.alu_ctrl == ALU_MULH) & op_b[XLEN-1], op_b});
            prod    = (2*XLEN)'(ma) * (2*XLEN)'(mb);
            mul_res = (bus.alu_ctrl == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
         end
      end else begin : g_nomul
         assign mul_res = '0;
      end
   endgenerate

   always_comb begin
      alu_res = '0;
      case (bus.alu_ctrl)
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_SUB:    alu_res = op_a - op_b;
         ALU_SLL:    alu_res = op_a << shamt;
         ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_SRL:    alu_res = op_a >> shamt;
         ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
         ALU_OR:     alu_res = op_a | op_b;
         ALU_AND:    alu_res = op_a & op_b;
         ALU_PASSB:  alu_res = op_b;
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = mul_res;
         default:    alu_res = '0;
      endcase
   end

   assign div_idle  = ~div_busy & ~div_done;
   assign div_start = bus.in_valid & is_div_op(bus.alu_ctrl) & div_idle;
   assign stall     = div_busy | div_start;
   assign bus.stall_out = rst_n & stall;

   div_unit #(.XLEN(XLEN)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (div_start),
      .op     (to_div_op(bus.alu_ctrl)),
      .a      (op_a),
      .b      (op_b),
      .busy   (div_busy),
      .done   (div_done),
      .result (div_result)
   );

   // Decode may change its inputs once the divide is accepted; keep what it presented at start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_ctrl  <= '0;
         hold_pc    <= '0;
         hold_store <= '0;
      end else if (div_start) begin
         hold_ctrl  <= '{rd_we: bus.rd_write_enable_in, rd_addr: bus.rd_write_addr_in,
                        res_src: bus.res_src_in, mem_we: bus.mem_write_enable_in};
         hold_pc    <= bus.next_pc_in;
         hold_store <= bus.rs2_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.exec_data_out        <= '0;
         bus.mem_write_data_out   <= '0;
         bus.mem_write_enable_out <= 1'b0;
         bus.next_pc_out          <= '0;
         bus.rd_write_enable_out  <= 1'b0;
         bus.rd_write_addr_out    <= '0;
         bus.res_src_out          <= '0;
      end else if (div_done) begin
         bus.exec_data_out        <= div_result;
         bus.mem_write_data_out   <= hold_store;
         bus.mem_write_enable_out <= hold_ctrl.mem_we;
         bus.next_pc_out          <= hold_pc;
         bus.rd_write_enable_out  <= hold_ctrl.rd_we;
         bus.rd_write_addr_out    <= hold_ctrl.rd_addr;
         bus.res_src_out          <= hold_ctrl.res_src;
      end else begin
         bus.exec_data_out        <= alu_res;
         bus.mem_write_data_out   <= bus.rs2_data;
         bus.mem_write_enable_out <= bus.in_valid & ~stall & bus.mem_write_enable_in;
         bus.next_pc_out          <= bus.next_pc_in;
         bus.rd_write_enable_out  <= bus.in_valid & ~stall & bus.rd_write_enable_in;
         bus.rd_write_addr_out    <= bus.rd_write_addr_in;
         bus.res_src_out          <= bus.res_src_in;
      end
   end

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage: ALU, multiply, divide timing/results, reset abort.
module tb_execute;
   import execute_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   execute_if #(.XLEN(32)) bus();
   execute #(.XLEN(32), .MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic src_b, input logic [31:0] imm);
      bus.in_valid            = 1'b1;
      bus.pc_in               = 32'h0000_0100;
      bus.next_pc_in          = 32'h0000_0104;
      bus.rs1_data            = a;
      bus.rs2_data            = b;
      bus.imm                 = imm;
      bus.alu_src_a           = 1'b0;
      bus.alu_src_b           = src_b;
      bus.alu_ctrl            = op;
      bus.rd_write_enable_in  = 1'b1;
      bus.rd_write_addr_in    = 5'd7;
      bus.res_src_in          = 2'd1;
      bus.mem_write_enable_in = 1'b0;
      #1;
   endtask

   task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic src_b, input logic [31:0] imm,
                      input logic [31:0] exp);
      issue(op, a, b, src_b, imm);
      chk({tag, "_stall"}, {31'b0, bus.stall_out}, 32'd0);
      tick();
      chk(tag, bus.exec_data_out, exp);
   endtask

   // Counts stalled cycles and downstream bubbles; corrupts inputs mid-divide to prove they are held.
   task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
      int n = 0;
      int bub = 0;
      issue(op, a, b, 1'b0, 32'h0);
      for (int i = 0; i < 40 && bus.stall_out === 1'b1; i++) begin
         n++;
         if (i == 5) begin
            bus.rs1_data         = 32'h1234_5678;
            bus.rd_write_addr_in = 5'd30;
            bus.next_pc_in       = 32'hDEAD_0000;
         end
         tick();
         if (bus.rd_write_enable_out === 1'b0 && bus.mem_write_enable_out === 1'b0) bub++;
      end
      chk({tag, "_stall_cycles"}, n, exp_stall);
      chk({tag, "_bubbles"}, bub, exp_stall);
      tick();
      chk(tag, bus.exec_data_out, exp);
      chk({tag, "_rd_we"}, {31'b0, bus.rd_write_enable_out}, 32'd1);
      chk({tag, "_rd_addr"}, {27'b0, bus.rd_write_addr_out}, 32'd7);
      chk({tag, "_next_pc"}, bus.next_pc_out, 32'h0000_0104);
   endtask

   initial begin
      issue(ALU_ADD, 32'h0, 32'h0, 1'b0, 32'h0);
      bus.in_valid = 1'b0;
      #12;
      chk("rst_exec_data", bus.exec_data_out, 32'h0);
      chk("rst_rd_we", {31'b0, bus.rd_write_enable_out}, 32'd0);
      chk("rst_mem_we", {31'b0, bus.mem_write_enable_out}, 32'd0);
      chk("rst_stall", {31'b0, bus.stall_out}, 32'd0);
      rst_n = 1'b1;
      tick();

      alu("add_wrap", ALU_ADD, 32'd5, 32'hFFFF_FFFD, 1'b0, 32'h0, 32'd2);
      chk("add_rd_we", {31'b0, bus.rd_write_enable_out}, 32'd1);
      chk("add_rd_addr", {27'b0, bus.rd_write_addr_out}, 32'd7);
      chk("add_res_src", {30'b0, bus.res_src_out}, 32'd1);
      alu("sra_imm", ALU_SRA, 32'h8000_0000, 32'h0, 1'b1, 32'd4, 32'hF800_0000);
      alu("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'd1);
      alu("slt", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'd0);
      alu("sub_wrap", ALU_SUB, 32'd0, 32'd1, 1'b0, 32'h0, 32'hFFFF_FFFF);
      alu("sll_amt5", ALU_SLL, 32'h0000_0003, 32'h0000_0021, 1'b0, 32'h0, 32'h0000_0006);
      alu("srl", ALU_SRL, 32'h8000_0000, 32'd31, 1'b0, 32'h0, 32'h0000_0001);

      issue(ALU_ADD, 32'h0, 32'h0, 1'b1, 32'd8);
      bus.alu_src_a = 1'b1;
      tick();
      chk("auipc_pc_src", bus.exec_data_out, 32'h0000_0108);

      issue(ALU_ADD, 32'd9, 32'd9, 1'b0, 32'h0);
      bus.in_valid = 1'b0;
      tick();
      chk("bubble_rd_we", {31'b0, bus.rd_write_enable_out}, 32'd0);

      run_div("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_div("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_div("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run_div("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33);
      run_div("divu_by0", ALU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
      run_div("rem_by0", ALU_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
      run_div("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
      run_div("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

      alu("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFFF_FFFE);
      alu("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
      alu("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFFF_FFFF);
      alu("mul", ALU_MUL, 32'h0001_0003, 32'h0000_0005, 1'b0, 32'h0, 32'h0005_000F);

      issue(ALU_ADD, 32'h0000_1000, 32'hCAFE_BABE, 1'b1, 32'd4);
      bus.mem_write_enable_in = 1'b1;
      bus.rd_write_enable_in  = 1'b0;
      tick();
      chk("store_addr", bus.exec_data_out, 32'h0000_1004);
      chk("store_data", bus.mem_write_data_out, 32'hCAFE_BABE);
      chk("store_mem_we", {31'b0, bus.mem_write_enable_out}, 32'd1);
      chk("store_rd_we", {31'b0, bus.rd_write_enable_out}, 32'd0);

      issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0);
      tick();
      repeat (10) tick();
      chk("abort_busy_stall", {31'b0, bus.stall_out}, 32'd1);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_exec_data", bus.exec_data_out, 32'h0);
      chk("abort_mem_wd", bus.mem_write_data_out, 32'h0);
      chk("abort_next_pc", bus.next_pc_out, 32'h0);
      chk("abort_rd_addr", {27'b0, bus.rd_write_addr_out}, 32'd0);
      chk("abort_stall", {31'b0, bus.stall_out}, 32'd0);
      #3;
      rst_n = 1'b1;
      issue(ALU_ADD, 32'd1, 32'd1, 1'b0, 32'h0);
      chk("post_rst_stall", {31'b0, bus.stall_out}, 32'd0);
      tick();
      chk("post_rst_add", bus.exec_data_out, 32'd2);
      chk("post_rst_rd_we", {31'b0, bus.rd_write_enable_out}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
